mmio_reg_fabric: RTL
====================

Name: mmio_reg_fabric

Overview:
Parametrised memory-mapped register fabric for the coprocessor bus. It replaces hard-wired per-coprocessor config registers with NUM_CH channels of REGS_PER_CH-1 double-buffered config words plus one read-only status word each. Behaviour:
- CPU writes land in shadow registers.
- Coprocessors see only active registers, which update atomically on a frame commit.
- Sits between the CPU data port and the physics, controller, VGA and collision coprocessors.

Parameters:
NUM_CH, 8, number of coprocessor channels (power of 2, >=2)
REGS_PER_CH, 8, words per channel including status word 0 (power of 2, >=2)
DATA_W, 32, register width
ADDR_W, 13, word-address width; bit ADDR_W-1 selects the MMIO region

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  request present
req_ready  out  1  fabric can accept a request
req_wren  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  unmapped address or write to status word
commit  in  1  single-cycle frame strobe: shadow -> active, all channels
ch_status  in  NUM_CH*DATA_W  per-channel status inputs (e.g. position, collision flags)
ch_cfg  out  NUM_CH*(REGS_PER_CH-1)*DATA_W  active config words; channel c word r sits at slice index c*(REGS_PER_CH-1)+(r-1)
ch_dirty  out  NUM_CH  channel has shadow writes not yet committed

Behaviour:
- Decode: CB=log2(NUM_CH), RB=log2(REGS_PER_CH).
  - reg = req_addr[RB+1:2]; ch = req_addr[RB+CB+1:RB+2].
  - Bits [1:0] are ignored.
  - Mapped iff req_addr[ADDR_W-1]=1 and req_addr[ADDR_W-2:RB+CB+2]=0.
- FSM with two states:
  - IDLE: req_ready=1. On req_valid, go to RESP and perform the access in that same cycle.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata/rsp_err are held stable until rsp_ready=1, then return to IDLE.
  - Throughput: at most one transaction per 2 cycles. Response appears exactly 1 cycle after acceptance when rsp_ready is held high.
- Read, mapped:
  - reg 0 returns ch_status[ch], sampled at the acceptance edge.
  - reg r>0 returns shadow[ch][r], not active.
- Write, mapped, reg>0: shadow[ch][r] <= req_wdata; ch_dirty[ch] <= 1.
- Error responses (rsp_err=1, rsp_rdata=0, no state change):
  - write to reg 0;
  - any unmapped access.
- Commit: on commit=1, every active[c][r] <= shadow[c][r] and ch_dirty <= 0, regardless of FSM state.
- Simultaneous commit and accepted write in the same cycle:
  - active takes the pre-write shadow value;
  - shadow takes the new data;
  - ch_dirty[ch] ends at 1 (the write wins over the clear).
- Active registers never change except on commit, so ch_cfg is glitch-free within a frame.
- Reset (asynchronous assert, synchronous release):
  - all shadow, active, ch_dirty, rsp_rdata, rsp_err = 0;
  - rsp_valid = 0; FSM = IDLE;
  - req_ready = 1 from the first clock after release.
- Reset during RESP drops the pending response.
- req_wdata, req_addr and req_wren are sampled only at acceptance; later changes are ignored.

Optional Feature:
MMIO_BYTE_ENABLE_EN
- Defined: adds input req_be [DATA_W/8]. A write updates only the shadow bytes whose enable is 1. ch_dirty is set only if req_be is non-zero. A write with req_be=0 to reg 0 still errors.
- Undefined: no req_be port; writes update the whole word.

Test Plan:
- Defaults, post-reset: write 0x12345678 to 0x1024 (ch1, reg1), then read 0x1024 -> rsp_rdata=0x12345678, rsp_err=0. ch_cfg ch1 word1 stays 0 and ch_dirty=8'b00000010 until commit; after a commit pulse ch_cfg ch1 word1=0x12345678 and ch_dirty=0.
- ch_status ch3=0x016000FA; read 0x1060 -> 0x016000FA. Write 0xFFFF to 0x1060 -> rsp_err=1, rsp_rdata=0, no state change.
- Read 0x0040 (top bit 0) and read 0x1100 (nonzero upper bits) -> rsp_err=1 each.
- Shadow ch0 reg2=0xA. Then write 0xB to 0x1008 in the same cycle as commit -> active=0xA, shadow=0xB, ch_dirty[0]=1. A second commit -> active=0xB.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored. Assert reset mid-RESP -> rsp_valid=0 immediately, all registers 0.
- With MMIO_BYTE_ENABLE_EN: shadow=0x11223344, write 0xAABBCCDD with req_be=4'b0101 -> shadow=0x11BB33DD.

Source files
------------

// File: rtl/mmio_reg_fabric_if.sv
// mmio_reg_fabric_if: request/response bus between the CPU data port and the register fabric
// Ports (signals):
//   req_valid/req_ready  request handshake
//   req_wren             1 = write, 0 = read
//   req_addr, req_wdata  request address and write data
//   req_be               per-byte write enables (only when MMIO_BYTE_ENABLE_EN is defined)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   read data and error flag
// Build option: MMIO_BYTE_ENABLE_EN adds req_be.
interface mmio_reg_fabric_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wren;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
`ifdef MMIO_BYTE_ENABLE_EN
   logic [DATA_W/8-1:0] req_be;
`endif
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   modport master (
      output req_valid, req_wren, req_addr, req_wdata, rsp_ready,
`ifdef MMIO_BYTE_ENABLE_EN
      output req_be,
`endif
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_wren, req_addr, req_wdata, rsp_ready,
`ifdef MMIO_BYTE_ENABLE_EN
      input  req_be,
`endif
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mmio_reg_fabric.sv
// mmio_reg_fabric: double-buffered per-channel config registers with read-only status words
// Ports:
//   clock      system clock, posedge
//   reset      asynchronous active-low reset
//   bus        mmio_reg_fabric_if.slave request/response bus
//   commit     frame strobe: copy every shadow word to its active word, clear ch_dirty
//   ch_status  per-channel status word, returned by reads of word 0
//   ch_cfg     active config words, channel c word r at slice c*(REGS_PER_CH-1)+(r-1)
//   ch_dirty   per-channel flag: shadow written since the last commit
// Build option: MMIO_BYTE_ENABLE_EN enables per-byte write masking via bus.req_be.
module mmio_reg_fabric #(
   parameter int NUM_CH      = 8,
   parameter int REGS_PER_CH = 8,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 13
) (
   input  logic                                      clock,
   input  logic                                      reset,
   mmio_reg_fabric_if.slave                          bus,
   input  logic                                      commit,
   input  logic [NUM_CH*DATA_W-1:0]                  ch_status,
   output logic [NUM_CH*(REGS_PER_CH-1)*DATA_W-1:0]  ch_cfg,
   output logic [NUM_CH-1:0]                         ch_dirty
);
   localparam int CB = $clog2(NUM_CH);
   localparam int RB = $clog2(REGS_PER_CH);
   localparam int NW = REGS_PER_CH - 1;
   localparam int NB = DATA_W / 8;
   typedef enum logic {IDLE, RESP} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] shadow_q [NUM_CH][NW];
   logic [DATA_W-1:0] shadow_d [NUM_CH][NW];
   logic [DATA_W-1:0] active_q [NUM_CH][NW];
   logic [DATA_W-1:0] active_d [NUM_CH][NW];
   logic [NUM_CH-1:0] dirty_q, dirty_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [RB-1:0]     reg_idx, word_idx;
   logic [CB-1:0]     ch;
   logic              mapped, accept, wr_ok, unused_addr;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] cur_word, new_word, status_word;
   assign reg_idx     = bus.req_addr[RB+1:2];
   assign ch          = bus.req_addr[RB+CB+1:RB+2];
   assign unused_addr = ^bus.req_addr[1:0];
   assign mapped      = bus.req_addr[ADDR_W-1] & ~|bus.req_addr[ADDR_W-2:RB+CB+2];
   // word 0 is status and has no storage, so shadow/active slot r-1 holds word r
   assign word_idx    = (reg_idx == '0) ? '0 : reg_idx - RB'(1);
   assign accept      = bus.req_valid & (state_q == IDLE);
   assign wr_ok       = accept & bus.req_wren & mapped & (reg_idx != '0);
   assign status_word = ch_status[ch*DATA_W +: DATA_W];
   assign cur_word    = shadow_q[ch][word_idx];
`ifdef MMIO_BYTE_ENABLE_EN
   assign be = bus.req_be;
`else
   assign be = '1;
`endif
   for (genvar b = 0; b < NB; b++) begin : g_be
      assign new_word[8*b +: 8] = be[b] ? bus.req_wdata[8*b +: 8] : cur_word[8*b +: 8];
   end
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign ch_dirty      = dirty_q;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar r = 0; r < NW; r++) begin : g_word
         assign ch_cfg[(c*NW+r)*DATA_W +: DATA_W] = active_q[c][r];
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (bus.req_valid ? RESP : IDLE) : (bus.rsp_ready ? IDLE : RESP);
   end
   always_comb begin
      rdata_d  = rdata_q;
      err_d    = err_q;
      shadow_d = shadow_q;
      active_d = active_q;
      if (accept) begin
         err_d   = ~mapped | (bus.req_wren & (reg_idx == '0));
         rdata_d = (err_d | bus.req_wren) ? '0 : ((reg_idx == '0) ? status_word : cur_word);
      end
      // commit copies the pre-write shadow; a same-cycle write lands in shadow only
      if (commit) active_d = shadow_q;
      if (wr_ok) shadow_d[ch][word_idx] = new_word;
      // a same-cycle write re-marks its channel after the commit clear
      dirty_d = commit ? '0 : dirty_q;
      if (wr_ok & (|be)) dirty_d[ch] = 1'b1;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         dirty_q  <= '0;
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         dirty_q  <= dirty_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end
endmodule
